// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, PC select codes and register index width
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    MEM_STALL     = 2'd1,
    REDIRECT_WAIT = 2'd2
  } state_t;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between EX load and ID sources
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 ex_valid,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  output logic                 Hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign Hazard = ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_redirect_ctrl.sv
// rtl/pipe_redirect_ctrl.sv - pipeline redirect/stall controller; statistics counters enabled by REDIRECT_STATS_EN
module pipe_redirect_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ExValid,
  input  logic                 ExJumpFlag,
  input  logic [XLEN-1:0]      ExJumpTarget,
  input  logic                 ExMemRead,
  input  logic [REG_IDX_W-1:0] ExRd,
  input  logic [REG_IDX_W-1:0] IdRs1,
  input  logic [REG_IDX_W-1:0] IdRs2,
  input  logic                 IdUseRs1,
  input  logic                 IdUseRs2,
  input  logic                 ImemReady,
  input  logic                 DmemBusy,
  output logic                 PcWrite,
  output logic                 PcSel,
  output logic [XLEN-1:0]      PcTarget,
  output logic                 IfIdWrite,
  output logic                 IdExWrite,
  output logic                 ExMemWrite,
  output logic                 IfIdFlush,
  output logic                 IdExFlush,
  output logic [CNT_W-1:0]     RedirectCnt,
  output logic [CNT_W-1:0]     StallCnt
);

  state_t          state, state_next;
  logic            pending, pending_next;
  logic [XLEN-1:0] target, target_next;

  logic            hazard;
  logic            ex_jump;
  logic            redirect_req;
  logic [XLEN-1:0] redirect_tgt;

  load_use_detect u_load_use_detect (
    .ex_valid    (ExValid),
    .ex_mem_read (ExMemRead),
    .ex_rd       (ExRd),
    .id_rs1      (IdRs1),
    .id_rs2      (IdRs2),
    .id_use_rs1  (IdUseRs1),
    .id_use_rs2  (IdUseRs2),
    .Hazard      (hazard)
  );

  // A latched redirect is older than anything now in EX, so it wins
  assign ex_jump      = ExValid && ExJumpFlag;
  assign redirect_req = pending || ex_jump;
  assign redirect_tgt = pending ? target : ExJumpTarget;

  // State, pending flag and held target; reset drops any pending redirect at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pending <= 1'b0;
      target  <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      target  <= target_next;
    end
  end

  // Next state and all pipeline controls, priority busy > redirect > hazard > fetch wait
  always_comb begin
    state_next   = state;
    pending_next = pending;
    target_next  = target;
    PcWrite      = 1'b0;
    PcSel        = PC_SEL_SEQ;
    PcTarget     = '0;
    IfIdWrite    = 1'b0;
    IdExWrite    = 1'b0;
    ExMemWrite   = 1'b0;
    IfIdFlush    = 1'b0;
    IdExFlush    = 1'b0;

    if (!rst_n) begin
      state_next   = RUN;
      pending_next = 1'b0;
      target_next  = '0;
      IfIdFlush    = 1'b1;
      IdExFlush    = 1'b1;
    end else if (DmemBusy) begin
      state_next = MEM_STALL;
      if (redirect_req) begin
        pending_next = 1'b1;
        target_next  = redirect_tgt;
      end
    end else if (redirect_req) begin
      PcSel      = PC_SEL_TGT;
      PcTarget   = redirect_tgt;
      PcWrite    = ImemReady;
      IfIdWrite  = 1'b1;
      IdExWrite  = 1'b1;
      ExMemWrite = 1'b1;
      IfIdFlush  = 1'b1;
      IdExFlush  = 1'b1;
      if (ImemReady) begin
        state_next   = RUN;
        pending_next = 1'b0;
      end else begin
        state_next   = REDIRECT_WAIT;
        pending_next = 1'b1;
        target_next  = redirect_tgt;
      end
    end else if (hazard) begin
      state_next = RUN;
      IdExWrite  = 1'b1;
      ExMemWrite = 1'b1;
      IdExFlush  = 1'b1;
    end else begin
      state_next = RUN;
      PcWrite    = ImemReady;
      IfIdWrite  = ImemReady;
      IfIdFlush  = !ImemReady;
      IdExWrite  = 1'b1;
      ExMemWrite = 1'b1;
    end
  end

`ifdef REDIRECT_STATS_EN
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Saturating counts of issued redirects and cycles without a PC update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (PcWrite && (PcSel == PC_SEL_TGT) && (redirect_cnt != '1))
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (!PcWrite && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign RedirectCnt = redirect_cnt;
  assign StallCnt    = stall_cnt;
`else
  assign RedirectCnt = '0;
  assign StallCnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// tb/tb_pipe_redirect_ctrl.sv - scoreboard bench for pipe_redirect_ctrl (expects REDIRECT_STATS_EN to match the RTL build)
module tb_pipe_redirect_ctrl;

  localparam int CNT_W = 3;
`ifdef REDIRECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ExValid, ExJumpFlag, ExMemRead;
  logic [31:0]      ExJumpTarget;
  logic [4:0]       ExRd, IdRs1, IdRs2;
  logic             IdUseRs1, IdUseRs2, ImemReady, DmemBusy;
  logic             PcWrite, PcSel, IfIdWrite, IdExWrite, ExMemWrite, IfIdFlush, IdExFlush;
  logic [31:0]      PcTarget;
  logic [CNT_W-1:0] RedirectCnt, StallCnt;

  pipe_redirect_ctrl #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ExValid(ExValid), .ExJumpFlag(ExJumpFlag), .ExJumpTarget(ExJumpTarget),
    .ExMemRead(ExMemRead), .ExRd(ExRd), .IdRs1(IdRs1), .IdRs2(IdRs2),
    .IdUseRs1(IdUseRs1), .IdUseRs2(IdUseRs2), .ImemReady(ImemReady), .DmemBusy(DmemBusy),
    .PcWrite(PcWrite), .PcSel(PcSel), .PcTarget(PcTarget),
    .IfIdWrite(IfIdWrite), .IdExWrite(IdExWrite), .ExMemWrite(ExMemWrite),
    .IfIdFlush(IfIdFlush), .IdExFlush(IdExFlush),
    .RedirectCnt(RedirectCnt), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [39:0] o;
    logic [1:0]  st;
    bit          cc;
    logic [CNT_W-1:0] rc;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   errors = 0;

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ev, jf, input logic [31:0] jt, input logic mr,
                        input logic [4:0] rd, rs1, rs2, input logic u1, u2, imr, busy);
    ExValid = ev; ExJumpFlag = jf; ExJumpTarget = jt; ExMemRead = mr;
    ExRd = rd; IdRs1 = rs1; IdRs2 = rs2; IdUseRs1 = u1; IdUseRs2 = u2;
    ImemReady = imr; DmemBusy = busy;
  endtask

  task automatic idle(input logic imr);
    set_in(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0, imr, 0);
  endtask

  // w = {IfIdWrite,IdExWrite,ExMemWrite}, f = {IfIdFlush,IdExFlush}
  task automatic push(input string nm, input logic pw, ps, input logic [31:0] t,
                      input logic [2:0] w, input logic [1:0] f, input logic [1:0] st,
                      input bit cc = 0, input int rc = 0, input int sc = 0);
    exp_t e;
    e.nm = nm;
    e.o  = {pw, ps, t, w, f};
    e.st = st;
    e.cc = cc;
    e.rc = STATS ? CNT_W'(rc) : '0;
    e.sc = STATS ? CNT_W'(sc) : '0;
    q.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest expectation each falling edge
  initial begin
    exp_t       e;
    logic [39:0] act;
    logic [1:0]  st_act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {PcWrite, PcSel, PcTarget, IfIdWrite, IdExWrite, ExMemWrite, IfIdFlush, IdExFlush};
        st_act = dut.state;
        tests++;
        if (act !== e.o || st_act !== e.st) begin
          errors++;
          $display("FAIL %s: outputs=%h state=%0d, required outputs=%h state=%0d",
                   e.nm, act, st_act, e.o, e.st);
        end
        if (e.cc) begin
          tests++;
          if (RedirectCnt !== e.rc || StallCnt !== e.sc) begin
            errors++;
            $display("FAIL %s_cnt: redirect=%0d stall=%0d, required redirect=%0d stall=%0d",
                     e.nm, RedirectCnt, StallCnt, e.rc, e.sc);
          end
        end
      end
    end
  end

  // Stimulus: one input vector and one expectation per cycle
  initial begin
    rst_n = 1'b0;
    idle(1'b1);

    go(); push("reset", 0, 0, 32'h0, 3'b000, 2'b11, 2'd0);
    go(); rst_n = 1'b1; idle(1);
    push("run_idle", 1, 0, 32'h0, 3'b111, 2'b00, 2'd0);

    go(); set_in(1, 1, 32'h100, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    push("jump_100", 1, 1, 32'h100, 3'b111, 2'b11, 2'd0);
    go(); idle(1); push("after_jump_100", 1, 0, 32'h0, 3'b111, 2'b00, 2'd0);

    go(); set_in(1, 1, 32'h200, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    push("jump_200_nordy", 0, 1, 32'h200, 3'b111, 2'b11, 2'd0);
    go(); idle(0); push("wait_200_a", 0, 1, 32'h200, 3'b111, 2'b11, 2'd2);
    go(); idle(0); push("wait_200_b", 0, 1, 32'h200, 3'b111, 2'b11, 2'd2);
    go(); idle(1); push("wait_200_go", 1, 1, 32'h200, 3'b111, 2'b11, 2'd2);
    go(); idle(1); push("after_200", 1, 0, 32'h0, 3'b111, 2'b00, 2'd0);

    go(); set_in(1, 0, 32'h0, 1, 5'd5, 5'd5, 5'd9, 1, 0, 1, 0);
    push("load_use_rs1", 0, 0, 32'h0, 3'b011, 2'b01, 2'd0);
    go(); idle(1); push("after_bubble", 1, 0, 32'h0, 3'b111, 2'b00, 2'd0);
    go(); set_in(1, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0);
    push("load_x0", 1, 0, 32'h0, 3'b111, 2'b00, 2'd0, 1, 2, 4);

    go(); set_in(1, 1, 32'h400, 1, 5'd7, 5'd3, 5'd7, 1, 1, 1, 0);
    push("jump_cancels_hazard", 1, 1, 32'h400, 3'b111, 2'b11, 2'd0);
    go(); set_in(1, 0, 32'h0, 1, 5'd7, 5'd3, 5'd7, 1, 1, 1, 0);
    push("load_use_rs2", 0, 0, 32'h0, 3'b011, 2'b01, 2'd0);
    go(); idle(0); push("fetch_wait", 0, 0, 32'h0, 3'b011, 2'b10, 2'd0);

    go(); set_in(1, 1, 32'h300, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    push("busy_jump_300", 0, 0, 32'h0, 3'b000, 2'b00, 2'd0);
    go(); set_in(0, 0, 32'hdead, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
    push("busy_hold", 0, 0, 32'h0, 3'b000, 2'b00, 2'd1);
    go(); set_in(0, 0, 32'hbeef, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    push("busy_release_300", 1, 1, 32'h300, 3'b111, 2'b11, 2'd1);
    go(); idle(1); push("after_300", 1, 0, 32'h0, 3'b111, 2'b00, 2'd0);

    go(); set_in(1, 1, 32'h500, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    push("jump_500_nordy", 0, 1, 32'h500, 3'b111, 2'b11, 2'd0);
    go(); idle(0); push("wait_500", 0, 1, 32'h500, 3'b111, 2'b11, 2'd2);
    go(); rst_n = 1'b0; idle(1);
    push("async_reset", 0, 0, 32'h0, 3'b000, 2'b11, 2'd0);
    go(); rst_n = 1'b1; idle(1);
    push("post_reset", 1, 0, 32'h0, 3'b111, 2'b00, 2'd0, 1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      go(); idle(0); push("long_fetch_wait", 0, 0, 32'h0, 3'b011, 2'b10, 2'd0);
    end
    go(); idle(1); push("saturate", 1, 0, 32'h0, 3'b111, 2'b00, 2'd0, 1, 0, 7);

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
